// File: rtl/ad_ip_jesd204_tpl_dac_pkg.sv
// Shared definitions for the JESD204 TPL DAC per-channel source stage.
// Holds the sample width, the dac_data_sel source codes and the PN
// generator seeds/taps used by the pattern source and its LFSR block.
package ad_ip_jesd204_tpl_dac_pkg;

    localparam int unsigned SAMPLE_W = 16;

    // Source codes driven by the register map on dac_data_sel.
    // Codes 8, 9, 10 and 12-15 are unassigned and output zero.
    typedef enum logic [3:0] {
        SEL_DDS      = 4'd0,
        SEL_PATTERN  = 4'd1,
        SEL_DMA      = 4'd2,
        SEL_ZERO     = 4'd3,
        SEL_PN7_INV  = 4'd4,
        SEL_PN15_INV = 4'd5,
        SEL_PN7      = 4'd6,
        SEL_PN15     = 4'd7,
        SEL_RAMP     = 4'd11
    } dac_sel_e;

    // Value of the delayed select after reset; never a legal active code,
    // so the first beat after reset is always treated as a selection change.
    localparam logic [3:0] SEL_RESET = 4'hF;

    // PN7 : x^7  + x^6  + 1
    localparam int unsigned  PN7_W     = 7;
    localparam int unsigned  PN7_TAP   = 6;
    localparam logic [6:0]   PN7_SEED  = 7'h7F;

    // PN15: x^15 + x^14 + 1
    localparam int unsigned  PN15_W    = 15;
    localparam int unsigned  PN15_TAP  = 14;
    localparam logic [14:0]  PN15_SEED = 15'h7FFF;

endpackage

// File: rtl/ad_ip_jesd204_tpl_dac_pn_gen.sv
// Fibonacci LFSR that produces BITS output bits per clock.
//   clk    : clock
//   rstn   : synchronous active-low reset, loads SEED
//   enable : advance the sequence; when low the state holds SEED
//   reload : restart from SEED for the beat produced this cycle
//   data   : BITS bits of the sequence; first bit lands in the MSB of
//            sample 0, last bit in the LSB of the last sample
module ad_ip_jesd204_tpl_dac_pn_gen
    import ad_ip_jesd204_tpl_dac_pkg::*;
#(
    parameter int unsigned WIDTH = 7,
    parameter int unsigned TAP   = 6,
    parameter int unsigned BITS  = 64,
    parameter logic [WIDTH-1:0] SEED = '1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            enable,
    input  logic            reload,
    output logic [BITS-1:0] data
);

    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] w_cur;
    logic [WIDTH-1:0] w_next;

    // Unrolled BITS-step advance; returns {next_state, beat_bits}.
    function automatic logic [WIDTH+BITS-1:0] pn_beat(input logic [WIDTH-1:0] seed);
        logic [WIDTH-1:0] s;
        logic [BITS-1:0]  b;
        s = seed;
        b = '0;
        for (int unsigned i = 0; i < BITS; i++) begin
            // Stream bit i -> sample i/16, bit position 15 - i%16.
            b[(i / SAMPLE_W) * SAMPLE_W + (SAMPLE_W - 1) - (i % SAMPLE_W)] = s[WIDTH-1];
            s = {s[WIDTH-2:0], s[WIDTH-1] ^ s[TAP-1]};
        end
        return {s, b};
    endfunction

    always_comb begin
        w_cur          = reload ? SEED : r_state;
        {w_next, data} = pn_beat(w_cur);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= SEED;
        end else if (enable) begin
            r_state <= w_next;
        end else begin
            r_state <= SEED;
        end
    end

endmodule

// File: rtl/ad_ip_jesd204_tpl_dac_pattern_src.sv
// Per-channel source stage of the JESD204 TPL DAC datapath (link clock).
// Selects DDS, DMA, fixed pattern, PN7/PN15 (true or inverted), ramp or
// zero and registers one beat of DATA_PATH_WIDTH 16-bit samples per clock.
//   link_clk, link_rstn : clock, synchronous active-low reset
//   dac_data_sel        : source select (quasi-static)
//   dac_pat_data_0/1    : fixed pattern words for even/odd samples
//   dds_data, dma_data  : source beats, sample 0 in the LSBs
//   dma_valid / dma_rd  : DMA handshake (dma_rd is combinational)
//   dac_data            : registered output beat
//   dac_dunf            : registered DMA underflow pulse
module ad_ip_jesd204_tpl_dac_pattern_src
    import ad_ip_jesd204_tpl_dac_pkg::*;
#(
    parameter int unsigned DATA_PATH_WIDTH = 4,
    parameter int unsigned DDS_ENABLE      = 1
) (
    input  logic                                  link_clk,
    input  logic                                  link_rstn,
    input  logic [3:0]                            dac_data_sel,
    input  logic [SAMPLE_W-1:0]                   dac_pat_data_0,
    input  logic [SAMPLE_W-1:0]                   dac_pat_data_1,
    input  logic [SAMPLE_W*DATA_PATH_WIDTH-1:0]   dds_data,
    input  logic [SAMPLE_W*DATA_PATH_WIDTH-1:0]   dma_data,
    input  logic                                  dma_valid,
    output logic                                  dma_rd,
    output logic [SAMPLE_W*DATA_PATH_WIDTH-1:0]   dac_data,
    output logic                                  dac_dunf
);

    localparam int unsigned BEAT_W = SAMPLE_W * DATA_PATH_WIDTH;

    logic [3:0]          r_sel_d;
    logic [SAMPLE_W-1:0] r_ramp;
    logic [BEAT_W-1:0]   r_dac_data;
    logic                r_dac_dunf;

    logic                w_change;
    logic                w_pn7_en;
    logic                w_pn15_en;
    logic [BEAT_W-1:0]   w_pn7;
    logic [BEAT_W-1:0]   w_pn15;
    logic [SAMPLE_W-1:0] w_ramp_base;
    logic [BEAT_W-1:0]   w_ramp_beat;
    logic [BEAT_W-1:0]   w_pat_beat;
    logic [BEAT_W-1:0]   w_data_next;
    logic                w_dunf_next;

    assign w_change  = (dac_data_sel != r_sel_d);
    assign w_pn7_en  = (dac_data_sel == SEL_PN7)  || (dac_data_sel == SEL_PN7_INV);
    assign w_pn15_en = (dac_data_sel == SEL_PN15) || (dac_data_sel == SEL_PN15_INV);
    assign dma_rd    = (dac_data_sel == SEL_DMA) && link_rstn;

    ad_ip_jesd204_tpl_dac_pn_gen #(
        .WIDTH (PN7_W),
        .TAP   (PN7_TAP),
        .BITS  (BEAT_W),
        .SEED  (PN7_SEED)
    ) i_pn7 (
        .clk    (link_clk),
        .rstn   (link_rstn),
        .enable (w_pn7_en),
        .reload (w_change),
        .data   (w_pn7)
    );

    ad_ip_jesd204_tpl_dac_pn_gen #(
        .WIDTH (PN15_W),
        .TAP   (PN15_TAP),
        .BITS  (BEAT_W),
        .SEED  (PN15_SEED)
    ) i_pn15 (
        .clk    (link_clk),
        .rstn   (link_rstn),
        .enable (w_pn15_en),
        .reload (w_change),
        .data   (w_pn15)
    );

    // A selection change restarts the ramp for the beat produced this cycle.
    assign w_ramp_base = w_change ? '0 : r_ramp;

    always_comb begin
        w_ramp_beat = '0;
        w_pat_beat  = '0;
        for (int unsigned k = 0; k < DATA_PATH_WIDTH; k++) begin
            w_ramp_beat[k*SAMPLE_W +: SAMPLE_W] = w_ramp_base + SAMPLE_W'(k);
            w_pat_beat[k*SAMPLE_W +: SAMPLE_W]  = (k % 2 == 0) ? dac_pat_data_0 : dac_pat_data_1;
        end
    end

    always_comb begin
        w_data_next = '0;
        w_dunf_next = 1'b0;
        case (dac_data_sel)
            SEL_DDS:      w_data_next = (DDS_ENABLE != 0) ? dds_data : '0;
            SEL_PATTERN:  w_data_next = w_pat_beat;
            SEL_DMA: begin
                if (dma_valid) begin
                    w_data_next = dma_data;
                end else begin
                    w_dunf_next = 1'b1;
                end
            end
            SEL_PN7_INV:  w_data_next = ~w_pn7;
            SEL_PN15_INV: w_data_next = ~w_pn15;
            SEL_PN7:      w_data_next = w_pn7;
            SEL_PN15:     w_data_next = w_pn15;
            SEL_RAMP:     w_data_next = w_ramp_beat;
            default:      w_data_next = '0;
        endcase
    end

    always_ff @(posedge link_clk) begin
        if (!link_rstn) begin
            r_sel_d    <= SEL_RESET;
            r_ramp     <= '0;
            r_dac_data <= '0;
            r_dac_dunf <= 1'b0;
        end else begin
            r_sel_d    <= dac_data_sel;
            r_ramp     <= (dac_data_sel == SEL_RAMP) ? w_ramp_base + SAMPLE_W'(DATA_PATH_WIDTH) : '0;
            r_dac_data <= w_data_next;
            r_dac_dunf <= w_dunf_next;
        end
    end

    assign dac_data = r_dac_data;
    assign dac_dunf = r_dac_dunf;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_pattern_src.sv
module tb_ad_ip_jesd204_tpl_dac_pattern_src;

    localparam int DPW = 4;
    localparam int BW  = 16 * DPW;

    logic          clk = 1'b0;
    logic          link_rstn;
    logic [3:0]    sel;
    logic [15:0]   pat0, pat1;
    logic [BW-1:0] dds, dma;
    logic          dma_valid;
    logic          dma_rd;
    logic [BW-1:0] dac_data;
    logic          dac_dunf;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ad_ip_jesd204_tpl_dac_pattern_src #(
        .DATA_PATH_WIDTH (DPW),
        .DDS_ENABLE      (1)
    ) dut (
        .link_clk       (clk),
        .link_rstn      (link_rstn),
        .dac_data_sel   (sel),
        .dac_pat_data_0 (pat0),
        .dac_pat_data_1 (pat1),
        .dds_data       (dds),
        .dma_data       (dma),
        .dma_valid      (dma_valid),
        .dma_rd         (dma_rd),
        .dac_data       (dac_data),
        .dac_dunf       (dac_dunf)
    );

    // Reference PN sequences from the recurrence a[n+W] = a[n] ^ a[n+1].
    bit pn7  [0:126];
    bit pn15 [0:32766];

    // Behavioural model: expected registered outputs.
    logic [BW-1:0] m_data;
    logic          m_dunf;
    bit            m_valid = 0;
    int            m_prev;
    int            m_idx;
    int            m_n;

    always @(posedge clk) begin
        if (!link_rstn) begin
            m_data = '0;
            m_dunf = 1'b0;
            m_prev = 15;
            m_idx  = 0;
            m_n    = 0;
        end else begin
            if (int'(sel) != m_prev) begin
                m_idx = 0;
                m_n   = 0;
            end
            m_data = '0;
            m_dunf = 1'b0;
            case (int'(sel))
                0: m_data = dds;
                1: for (int k = 0; k < DPW; k++) m_data[16*k +: 16] = (k % 2 == 1) ? pat1 : pat0;
                2: if (dma_valid) m_data = dma; else m_dunf = 1'b1;
                4, 5, 6, 7: begin
                    for (int i = 0; i < BW; i++) begin
                        bit b;
                        b = (sel == 4 || sel == 6) ? pn7[(m_idx + i) % 127] : pn15[(m_idx + i) % 32767];
                        if (sel == 4 || sel == 5) b = ~b;
                        m_data[16*(i/16) + 15 - (i%16)] = b;
                    end
                    m_idx = m_idx + BW;
                end
                11: begin
                    for (int k = 0; k < DPW; k++) m_data[16*k +: 16] = 16'((m_n * DPW + k) % 65536);
                    m_n = m_n + 1;
                end
                default: m_data = '0;
            endcase
            m_prev = int'(sel);
        end
        m_valid = 1;
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            n_cmp++;
            if (dac_data !== m_data) begin
                n_bad++;
                $display("FAIL model_data t=%0t sel=%0d actual=%h required=%h", $time, sel, dac_data, m_data);
            end
            n_cmp++;
            if (dac_dunf !== m_dunf) begin
                n_bad++;
                $display("FAIL model_dunf t=%0t sel=%0d actual=%b required=%b", $time, sel, dac_dunf, m_dunf);
            end
            n_cmp++;
            if (dma_rd !== ((sel == 4'd2) && link_rstn)) begin
                n_bad++;
                $display("FAIL model_dma_rd t=%0t sel=%0d actual=%b required=%b", $time, sel, dma_rd,
                         ((sel == 4'd2) && link_rstn));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    initial begin
        for (int n = 0; n < 127; n++)   pn7[n]  = (n < 7)  ? 1'b1 : pn7[n-7]   ^ pn7[n-6];
        for (int n = 0; n < 32767; n++) pn15[n] = (n < 15) ? 1'b1 : pn15[n-15] ^ pn15[n-14];

        link_rstn = 1'b0;
        sel       = 4'd1;
        pat0      = 16'h1234;
        pat1      = 16'hABCD;
        dds       = 64'h0123_4567_89AB_CDEF;
        dma       = 64'h1;
        dma_valid = 1'b0;

        // Reset held 3 cycles with the pattern selected.
        repeat (3) tick();
        chk("reset_data", dac_data, '0);
        chk("reset_dunf", {63'b0, dac_dunf}, '0);

        // First beat after release is the fixed pattern.
        link_rstn = 1'b1;
        tick();
        chk("pattern", dac_data, 64'hABCD_1234_ABCD_1234);

        sel = 4'd0;
        tick();
        chk("dds", dac_data, 64'h0123_4567_89AB_CDEF);

        // PN7 from seed after 3 -> 6, then inverted.
        sel = 4'd3;
        repeat (2) tick();
        chk("zero", dac_data, '0);
        sel = 4'd6;
        tick();
        chk("pn7_first", {48'b0, dac_data[15:0]}, 64'hFE04);
        repeat (130) tick();
        sel = 4'd4;
        tick();
        chk("pn7_inv_first", {48'b0, dac_data[15:0]}, 64'h01FB);
        repeat (130) tick();

        // PN15, then re-select 7 -> 3 -> 7 and run a full period.
        sel = 4'd7;
        tick();
        chk("pn15_first", {48'b0, dac_data[15:0]}, 64'hFFFE);
        repeat (5) tick();
        sel = 4'd3;
        repeat (2) tick();
        sel = 4'd7;
        tick();
        chk("pn15_reselect", {48'b0, dac_data[15:0]}, 64'hFFFE);
        repeat (520) tick();
        sel = 4'd5;
        repeat (5) tick();

        // Ramp across the 16-bit wrap.
        sel = 4'd11;
        tick();
        chk("ramp_beat0", dac_data, 64'h0003_0002_0001_0000);
        repeat (16383) tick();
        chk("ramp_beat16383", dac_data, 64'hFFFF_FFFE_FFFD_FFFC);
        tick();
        chk("ramp_beat16384", dac_data, 64'h0003_0002_0001_0000);
        repeat (3) tick();

        // Reset mid PN7 sequence restarts from seed.
        sel = 4'd6;
        repeat (5) tick();
        link_rstn = 1'b0;
        tick();
        chk("midreset_data", dac_data, '0);
        link_rstn = 1'b1;
        tick();
        chk("midreset_pn7", {48'b0, dac_data[15:0]}, 64'hFE04);

        // Unassigned codes output zero; no underflow outside DMA mode.
        for (int c = 8; c < 16; c++) begin
            if (c != 11) begin
                sel = 4'(c);
                tick();
                chk("unassigned_zero", dac_data, '0);
            end
        end

        // DMA handshake and a one-cycle underflow.
        sel       = 4'd2;
        dma_valid = 1'b1;
        #1;
        chk("dma_rd", {63'b0, dma_rd}, 64'h1);
        tick();
        chk("dma_data", dac_data, 64'h1);
        chk("dma_nodunf", {63'b0, dac_dunf}, '0);
        dma_valid = 1'b0;
        tick();
        chk("dunf_data", dac_data, '0);
        chk("dunf_flag", {63'b0, dac_dunf}, 64'h1);
        dma_valid = 1'b1;
        tick();
        chk("dunf_clear", {63'b0, dac_dunf}, '0);
        chk("dma_resume", dac_data, 64'h1);

        // dma_rd is gated by reset.
        link_rstn = 1'b0;
        #1;
        chk("dma_rd_in_reset", {63'b0, dma_rd}, '0);
        repeat (2) tick();
        link_rstn = 1'b1;
        sel       = 4'd3;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
